bubble_sort_engine: RTL

//   Holds the bar-height array and runs a bubble sort on it, one visible step per STEP_CYCLES clocks.

---
 rtl/bubble_sort_pkg.sv | 24 ++
 rtl/bubble_sort_engine_if.sv | 31 +++
 rtl/bubble_sort_engine_step_timer.sv | 36 +++
 rtl/bubble_sort_engine.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bubble_sort_pkg.sv
// Shared types and defaults for the bubble-sort engine and the OLED bar renderer.
// The optional early-exit feature of the engine is enabled by BUBBLE_EARLY_EXIT_EN.
package bubble_sort_pkg;

    localparam int unsigned N_BARS   = 5;
    localparam int unsigned HEIGHT_W = 7;

    // RGB565 bar colours used by the renderer; the active pair is drawn highlighted.
    localparam logic [15:0] BAR_COLOUR        = 16'h07E0;
    localparam logic [15:0] BAR_ACTIVE_COLOUR = 16'hF800;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_SWAP,
        ST_DONE
    } state_e;

    // Descending staircase so a fresh reset shows the worst case for the sort.
    function automatic int unsigned reset_height(input int unsigned i, input int unsigned n);
        return (n - i) * 10;
    endfunction

endpackage

// File: rtl/bubble_sort_engine_if.sv
// Control and status bundle between the sort controller and bubble_sort_engine.
interface bubble_sort_engine_if #(
    parameter int unsigned N_BARS   = bubble_sort_pkg::N_BARS,
    parameter int unsigned HEIGHT_W = bubble_sort_pkg::HEIGHT_W
);
    localparam int unsigned IDX_W = (N_BARS > 1) ? $clog2(N_BARS) : 1;

    logic                       start;
    logic                       pause;
    logic                       load_en;
    logic [IDX_W-1:0]           load_idx;
    logic [HEIGHT_W-1:0]        load_val;
    logic [N_BARS*HEIGHT_W-1:0] heights_flat;
    logic [IDX_W-1:0]           cmp_idx;
    logic                       cmp_valid;
    logic                       swap_active;
    logic [7:0]                 swap_count;
    logic                       busy;
    logic                       done;

    modport master (
        output start, pause, load_en, load_idx, load_val,
        input  heights_flat, cmp_idx, cmp_valid, swap_active, swap_count, busy, done
    );

    modport slave (
        input  start, pause, load_en, load_idx, load_val,
        output heights_flat, cmp_idx, cmp_valid, swap_active, swap_count, busy, done
    );

endinterface

// File: rtl/bubble_sort_engine_step_timer.sv
// Step pacing counter: emits a one-cycle tick every STEP_CYCLES enabled clocks.
module step_timer #(
    parameter int unsigned STEP_CYCLES = 625000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int unsigned    CntW    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = en_i && (cnt_q == CntLast);
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bubble_sort_engine.sv
// Bar-height array with a visible, step-paced bubble sort and compare/swap cursor outputs.
// Define BUBBLE_EARLY_EXIT_EN to finish as soon as a pass makes no swaps.
module bubble_sort_engine #(
    parameter int unsigned N_BARS      = bubble_sort_pkg::N_BARS,
    parameter int unsigned HEIGHT_W    = bubble_sort_pkg::HEIGHT_W,
    parameter int unsigned STEP_CYCLES = 625000
) (
    input logic                 clk,
    input logic                 reset,
    bubble_sort_engine_if.slave bus_io
);
    import bubble_sort_pkg::*;

    localparam int unsigned IDX_W = (N_BARS > 1) ? $clog2(N_BARS) : 1;
`ifdef BUBBLE_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    state_e              state_q, state_d;
    logic [HEIGHT_W-1:0] heights_q [N_BARS];
    logic [HEIGHT_W-1:0] heights_d [N_BARS];
    logic [IDX_W-1:0]    j_q, j_d, j_p1, pass_q, pass_d;
    logic                swapped_q, swapped_d;
    logic                start_pend_q, start_pend_d;
    logic [7:0]          swap_cnt_q, swap_cnt_d;
    logic                busy_q, swap_act_q, done_q;
    logic                timer_en, timer_clr, tick, start_req, advance;
    int unsigned         limit;

    assign j_p1     = j_q + 1'b1;
    assign timer_en = ((state_q == ST_COMPARE) || (state_q == ST_SWAP)) && !bus_io.pause;

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clk   (clk),
        .reset (reset),
        .en_i  (timer_en),
        .clr_i (timer_clr),
        .tick_o(tick)
    );

    always_comb begin
        state_d      = state_q;
        heights_d    = heights_q;
        j_d          = j_q;
        pass_d       = pass_q;
        swapped_d    = swapped_q;
        swap_cnt_d   = swap_cnt_q;
        start_pend_d = start_pend_q;
        timer_clr    = 1'b0;
        advance      = 1'b0;
        start_req    = bus_io.start | start_pend_q;
        limit        = N_BARS - 1 - 32'(pass_q);

        if (!bus_io.pause) begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    // A start coinciding with a load is deferred so the load lands first.
                    if (bus_io.load_en) begin
                        if (32'(bus_io.load_idx) < N_BARS) begin
                            heights_d[bus_io.load_idx] = bus_io.load_val;
                        end
                        state_d      = ST_IDLE;
                        start_pend_d = start_req;
                    end else if (start_req) begin
                        state_d      = ST_COMPARE;
                        j_d          = '0;
                        pass_d       = '0;
                        swapped_d    = 1'b0;
                        swap_cnt_d   = '0;
                        start_pend_d = 1'b0;
                        timer_clr    = 1'b1;
                    end
                end
                ST_COMPARE: begin
                    if (tick) begin
                        if (heights_q[j_q] > heights_q[j_p1]) begin
                            state_d = ST_SWAP;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                ST_SWAP: begin
                    if (tick) begin
                        heights_d[j_q]  = heights_q[j_p1];
                        heights_d[j_p1] = heights_q[j_q];
                        swapped_d       = 1'b1;
                        if (swap_cnt_q != 8'hFF) begin
                            swap_cnt_d = swap_cnt_q + 8'd1;
                        end
                        advance = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (advance) begin
            if (32'(j_p1) < limit) begin
                j_d     = j_p1;
                state_d = ST_COMPARE;
            end else begin
                j_d    = '0;
                pass_d = pass_q + 1'b1;
                if ((32'(pass_q) + 1 == N_BARS - 1) || (EarlyExit && !swapped_d)) begin
                    state_d = ST_DONE;
                end else begin
                    swapped_d = 1'b0;
                    state_d   = ST_COMPARE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            for (int unsigned i = 0; i < N_BARS; i++) begin
                heights_q[i] <= HEIGHT_W'(reset_height(i, N_BARS));
            end
            j_q          <= '0;
            pass_q       <= '0;
            swapped_q    <= 1'b0;
            start_pend_q <= 1'b0;
            swap_cnt_q   <= '0;
            busy_q       <= 1'b0;
            swap_act_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            heights_q    <= heights_d;
            j_q          <= j_d;
            pass_q       <= pass_d;
            swapped_q    <= swapped_d;
            start_pend_q <= start_pend_d;
            swap_cnt_q   <= swap_cnt_d;
            busy_q       <= (state_d == ST_COMPARE) || (state_d == ST_SWAP);
            swap_act_q   <= (state_d == ST_SWAP);
            done_q       <= (state_d == ST_DONE);
        end
    end

    for (genvar g = 0; g < N_BARS; g++) begin : g_flat
        assign bus_io.heights_flat[g*HEIGHT_W +: HEIGHT_W] = heights_q[g];
    end

    assign bus_io.cmp_idx     = j_q;
    assign bus_io.cmp_valid   = busy_q;
    assign bus_io.busy        = busy_q;
    assign bus_io.swap_active = swap_act_q;
    assign bus_io.swap_count  = swap_cnt_q;
    assign bus_io.done        = done_q;

endmodule
